// File: rtl/ram_loader.sv
// Byte-stream RAM loader: receives a framed program image (sync, length, payload,
// checksum), writes the payload into RAM and releases the CPU from reset on success.
package arch_defs_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
endpackage

module ram_loader #(
  parameter int                    ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  // Length holds values up to 2^ADDR_WIDTH, so it needs one bit more than an address.
  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = (DATA_WIDTH > LW) ? DATA_WIDTH : LW;
  localparam logic [CW-1:0] DEPTH_C = CW'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_SYNC, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ram_we_q, rx_ready_q, cpu_reset_q, load_done_q, load_error_q;

  logic                  fire;
  logic [CW-1:0]         rx_ext;
  logic [LW-1:0]         addr_next;

  assign fire      = rx_valid && rx_ready_q;
  assign rx_ext    = CW'(rx_data);
  assign addr_next = {1'b0, addr_q} + LW'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    wdata_d = wdata_q;
    case (state_q)
      S_SYNC, S_DONE, S_ERROR: begin
        if (fire && rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (fire) begin
          if (rx_ext == '0 || rx_ext > DEPTH_C) begin
            state_d = S_ERROR;
          end else begin
            len_d   = LW'(rx_ext);
            addr_d  = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          wdata_d = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_next[ADDR_WIDTH-1:0];
        state_d = (addr_next == len_q) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (fire) state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SYNC;
      len_q        <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      wdata_q      <= '0;
      ram_we_q     <= 1'b0;
      rx_ready_q   <= 1'b1;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      wdata_q      <= wdata_d;
      ram_we_q     <= (state_d == S_WRITE);
      rx_ready_q   <= (state_d != S_WRITE);
      cpu_reset_q  <= (state_d != S_DONE);
      load_done_q  <= (state_d == S_DONE);
      load_error_q <= (state_d == S_ERROR);
    end
  end

  assign rx_ready   = rx_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: expected RAM writes go into a queue that a negedge monitor
// drains on every ram_we; status levels are compared directly after each byte.
module tb_ram_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_reset;
  logic       load_done;
  logic       load_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write, and rx_ready
  // must be low exactly while the strobe is high.
  always @(negedge clk) begin
    if (ram_we || !rx_ready) begin
      checks++;
      if (ram_we !== !rx_ready) begin
        errors++;
        $display("[TB] FAIL ready_vs_we: rx_ready=%0b ram_we=%0b, required rx_ready=!ram_we", rx_ready, ram_we);
      end
    end
    if (ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got %02h@%0d, required no write", ram_wdata, ram_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data) begin
          errors++;
          $display("[TB] FAIL ram_write: got %02h@%0d, required %02h@%0d", ram_wdata, ram_addr, e.data, e.addr);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Offers one byte and returns at the negedge following the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b);
    bit got = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      if (rx_ready) got = 1;
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: byte %02h not accepted, required accept within 20 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkStatus(input string name, input logic done, input logic err, input logic cpu);
    checkOutput({name, "_load_done"}, 32'(load_done), 32'(done));
    checkOutput({name, "_load_error"}, 32'(load_error), 32'(err));
    checkOutput({name, "_cpu_reset"}, 32'(cpu_reset), 32'(cpu));
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_ram_we"}, 32'(ram_we), 32'd0);
    checkOutput({name, "_rx_ready"}, 32'(rx_ready), 32'd1);
    checkOutput({name, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({name, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    checkStatus(name, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] sum16;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    idle(1);

    // Good 3-byte frame; CPU released right after the checksum transfer.
    expectWrite(4'd0, 8'h11);
    expectWrite(4'd1, 8'h22);
    expectWrite(4'd2, 8'h33);
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    checkStatus("pre_chk", 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h66);
    idle(0);
    checkStatus("frame_a", 1'b1, 1'b0, 1'b0);

    // Sync byte in DONE re-arms the loader and holds the CPU in reset again.
    applyStimulus(8'hA5);
    checkStatus("resync_done", 1'b0, 1'b0, 1'b1);

    // Bad checksum (0x10+0x20=0x30, sent 0x31).
    expectWrite(4'd0, 8'h10);
    expectWrite(4'd1, 8'h20);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h31);
    checkStatus("bad_chk", 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h33);
    checkStatus("error_ignore", 1'b0, 1'b1, 1'b1);

    expectWrite(4'd0, 8'h07);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h07);
    applyStimulus(8'h07);
    checkStatus("frame_one", 1'b1, 1'b0, 1'b0);

    // Non-sync bytes are ignored in DONE; zero and oversize lengths are rejected.
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkStatus("done_ignore", 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    checkStatus("len_zero", 1'b0, 1'b1, 1'b1);
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    checkStatus("len_17", 1'b0, 1'b1, 1'b1);

    // Full-depth frame A0..AF streamed back-to-back, with a stall in the middle;
    // A5 at index 5 must be stored as data. Sum = 0xA78 mod 256 = 0x78.
    sum16 = 8'h78;
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    for (int k = 0; k < 16; k++) begin
      expectWrite(4'(k), 8'hA0 + 8'(k));
      applyStimulus(8'hA0 + 8'(k));
      if (k == 7) begin
        idle(4);
        checkOutput("stall_ram_we", 32'(ram_we), 32'd0);
        checkOutput("stall_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("stall_ram_addr", 32'(ram_addr), 32'd8);
        checkOutput("stall_ram_wdata", 32'(ram_wdata), 32'hA7);
      end
    end
    checkStatus("pre_chk16", 1'b0, 1'b0, 1'b1);
    applyStimulus(sum16);
    checkStatus("frame_16", 1'b1, 1'b0, 1'b0);

    // Reset mid-frame with a sync byte on the bus: the byte is dropped.
    expectWrite(4'd0, 8'h01);
    expectWrite(4'd1, 8'h02);
    applyStimulus(8'hA5);
    applyStimulus(8'h04);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    reset    = 1'b1;
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    @(negedge clk);
    checkResetValues("mid_reset");
    reset = 1'b0;
    idle(2);
    checkResetValues("post_reset");

    expectWrite(4'd0, 8'hAA);
    expectWrite(4'd1, 8'hBB);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'h65);
    checkStatus("frame_after_reset", 1'b1, 1'b0, 1'b0);

    idle(3);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
